sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer that assembles a qualified serial bit stream into WIDTH-bit words and presents each word through a one-deep valid/ready output buffer. It sits directly upstream of the 4-bit parallel-in/parallel-out register stage and produces the parallel word that stage loads. It adds frame alignment, backpressure handling and sticky error flags, so the downstream register only ever sees complete, aligned words.

---
 rtl/sipo_deser.sv | 98 +++++++++
 tb/tb_sipo_deser.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles qualified serial bits into WIDTH-bit words
// and holds each word in a one-deep valid/ready buffer with sticky overflow/frame error flags.
module sipo_deser #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sof,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overflow,
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;
  logic             word_done, drain, ovf_set, ferr_set;

  always_comb begin
    sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    ferr_set  = 1'b0;
    if (sin_valid) begin
      if (sin_sof) begin
        // Realign: drop the partial word and restart with this bit as bit 0.
        sr_d     = MSB_FIRST ? WIDTH'(sin) : {sin, {(WIDTH-1){1'b0}}};
        cnt_d    = CntW'(1);
        ferr_set = (cnt_q != '0);
      end else begin
        sr_d = sr_shift;
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          word_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    drain        = pout_valid_q & pout_ready;
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    ovf_set      = 1'b0;
    if (word_done) begin
      if (!pout_valid_q || drain) begin
        pout_d       = sr_shift;
        pout_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (drain) begin
      pout_valid_d = 1'b0;
    end
    // A new error event on the same edge as clear wins.
    overflow_d  = ovf_set | (overflow_q & ~clear);
    frame_err_d = ferr_set | (frame_err_q & ~clear);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Randomized and directed bench for sipo_deser; an MSB-first and an LSB-first instance share
// the stimulus and are checked every cycle against a word-level model.
module tb_sipo_deser;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, sin_sof = 1'b0, clear = 1'b0, pout_ready = 1'b0;

  logic [W-1:0] pout_m, pout_l;
  logic         valid_m, valid_l, ovf_m, ovf_l, ferr_m, ferr_l;

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = MSB-first instance, 1 = LSB-first instance.
  int           m_cnt   [2];
  logic [W-1:0] m_acc   [2];
  logic [W-1:0] m_pout  [2];
  bit           m_valid [2];
  bit           m_ovf   [2];
  bit           m_ferr  [2];

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof), .clear(clear),
    .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready), .overflow(ovf_m),
    .frame_err(ferr_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof), .clear(clear),
    .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready), .overflow(ovf_l),
    .frame_err(ferr_l)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_acc[i] = '0; m_pout[i] = '0;
      m_valid[i] = 0; m_ovf[i] = 0; m_ferr[i] = 0;
    end
  endtask

  // Word-level view: count bits, build the word arithmetically, then offer it to the buffer.
  task automatic model_step(input int i);
    bit           drain, done, ovf_set, ferr_set;
    logic [W-1:0] word;
    drain = m_valid[i] && pout_ready;
    done = 0; ovf_set = 0; ferr_set = 0; word = '0;
    if (sin_valid) begin
      if (sin_sof) begin
        ferr_set = (m_cnt[i] != 0);
        m_cnt[i] = 1;
        m_acc[i] = W'(sin);
      end else begin
        if (i == 0) m_acc[i] = (m_acc[i] << 1) | W'(sin);
        else        m_acc[i] = m_acc[i] | (W'(sin) << m_cnt[i]);
        m_cnt[i]++;
        if (m_cnt[i] == W) begin
          done = 1; word = m_acc[i]; m_cnt[i] = 0; m_acc[i] = '0;
        end
      end
    end
    if (done) begin
      if (!m_valid[i] || drain) begin m_pout[i] = word; m_valid[i] = 1; end
      else ovf_set = 1;
    end else if (drain) begin
      m_valid[i] = 0;
    end
    m_ovf[i]  = ovf_set  || (m_ovf[i]  && !clear);
    m_ferr[i] = ferr_set || (m_ferr[i] && !clear);
  endtask

  // Compare process: update the model on each edge / reset drop, check 1 time unit later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin model_step(0); model_step(1); end
      #1;
      check("msb pout",       32'(pout_m),  32'(m_pout[0]));
      check("msb pout_valid", 32'(valid_m), 32'(m_valid[0]));
      check("msb overflow",   32'(ovf_m),   32'(m_ovf[0]));
      check("msb frame_err",  32'(ferr_m),  32'(m_ferr[0]));
      check("lsb pout",       32'(pout_l),  32'(m_pout[1]));
      check("lsb pout_valid", 32'(valid_l), 32'(m_valid[1]));
      check("lsb overflow",   32'(ovf_l),   32'(m_ovf[1]));
      check("lsb frame_err",  32'(ferr_l),  32'(m_ferr[1]));
    end
  end

  task automatic drive(input logic b, input logic v, input logic s);
    @(negedge clk);
    sin = b; sin_valid = v; sin_sof = s;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int k = W - 1; k >= 0; k--) drive(w[k], 1'b1, 1'b0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst pout", 32'(pout_m), 32'h0);
    check("rst pout_valid", 32'(valid_m), 32'h0);
    check("rst overflow", 32'(ovf_l), 32'h0);
    check("rst frame_err", 32'(ferr_l), 32'h0);
    rst = 1'b1;

    // Back-to-back 1,0,1,1
    pout_ready = 1'b1;
    send_word(4'b1011);
    drive(1'b0, 1'b0, 1'b0);
    check("b2b msb word", 32'(pout_m), 32'hB);
    check("b2b lsb word", 32'(pout_l), 32'hD);
    check("b2b valid", 32'(valid_m), 32'h1);
    drive(1'b0, 1'b0, 1'b0);
    check("b2b one-cycle valid", 32'(valid_m), 32'h0);

    // Same stream with gaps
    drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("gap msb word", 32'(pout_m), 32'hB);
    check("gap lsb word", 32'(pout_l), 32'hD);
    drive(1'b0, 1'b0, 1'b0);

    // Backpressure: second word is dropped
    pout_ready = 1'b0;
    send_word(4'b1011);
    send_word(4'b0110);
    drive(1'b0, 1'b0, 1'b0);
    check("bp held word", 32'(pout_m), 32'hB);
    check("bp valid", 32'(valid_m), 32'h1);
    check("bp overflow", 32'(ovf_m), 32'h1);
    pout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    pout_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("bp drained", 32'(valid_m), 32'h0);
    check("bp pout kept", 32'(pout_m), 32'hB);
    clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("clear overflow", 32'(ovf_m), 32'h0);

    // Full buffer drains on the same edge the next word completes
    send_word(4'b1011);
    drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    pout_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("swap word", 32'(pout_m), 32'h6);
    check("swap valid", 32'(valid_m), 32'h1);
    check("swap no overflow", 32'(ovf_m), 32'h0);
    drive(1'b0, 1'b0, 1'b0);

    // Frame realignment mid-word
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0); drive(1'b0, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("sof frame_err", 32'(ferr_m), 32'h1);
    check("sof msb word", 32'(pout_m), 32'h5);
    check("sof lsb word", 32'(pout_l), 32'hA);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-word
    drive(1'b1, 1'b1, 1'b0); drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async rst pout", 32'(pout_m), 32'h0);
    check("async rst frame_err", 32'(ferr_m), 32'h0);
    check("async rst lsb pout", 32'(pout_l), 32'h0);
    @(negedge clk);
    sin_valid = 1'b0;
    rst = 1'b1;
    send_word(4'b1001);
    drive(1'b0, 1'b0, 1'b0);
    check("post-rst word", 32'(pout_m), 32'h9);
    check("post-rst valid", 32'(valid_l), 32'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      sin        = 1'($urandom);
      sin_valid  = ($urandom_range(3) != 0);
      sin_sof    = ($urandom_range(15) == 0);
      pout_ready = 1'($urandom);
      clear      = ($urandom_range(31) == 0);
    end
    drive(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
